// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg
// Shared definitions for the memory-access stage:
//   - RV32 load/store func3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - handshake state enum (IDLE, WAIT)
//   - default timeout for an outstanding memory access
//   - access-size helper used when checking alignment
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  // Every unrecognised encoding is treated as a word access.
  function automatic size_e access_size(input logic [2:0] func3, input logic is_store);
    size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (func3 == F3_B)      sz = SZ_BYTE;
      else if (func3 == F3_H) sz = SZ_HALF;
    end else begin
      if (func3 == F3_B || func3 == F3_BU)      sz = SZ_BYTE;
      else if (func3 == F3_H || func3 == F3_HU) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align
// Purely combinational byte/halfword lane steering for the memory stage.
// Ports:
//   func3_i      : RV32 load/store size and sign encoding
//   offset_i     : low two bits of the byte address
//   store_data_i : register value to be stored
//   read_word_i  : aligned word returned by the data memory
//   wstrb_o      : byte enables for a store
//   wdata_o      : store data replicated across all lanes of its size
//   load_data_o  : selected and sign/zero extended load value
module load_store_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: data is replicated so memory can pick it from whichever lane the strobe enables.
  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = store_data_i;
    case (func3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        wstrb_o = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: half selection ignores offset bit 0, so misaligned halves read the containing half.
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = read_word_i[7:0];
      2'd1:    byte_sel = read_word_i[15:8];
      2'd2:    byte_sel = read_word_i[23:16];
      default: byte_sel = read_word_i[31:24];
    endcase
    half_sel = offset_i[1] ? read_word_i[31:16] : read_word_i[15:0];

    load_data_o = read_word_i;
    case (func3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'b0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'b0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage sitting after execute. Issues one data-memory
// request at a time over a REQ/ACK handshake, stalls upstream while it is
// outstanding, abandons it after MEM_TIMEOUT wait cycles, and holds the
// MEM/WB register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no request, one-cycle MISALIGN pulse, no writeback). Without it
// the offending low address bits are ignored and MISALIGN is tied low.
// Ports:
//   CLK, RST            : clock (rising edge), async active-high reset
//   EX_*                : execute-stage result, store data, rd, func3, controls
//   MEM_REQ/WE/ADDR/
//   WDATA/WSTRB         : registered request to data memory
//   MEM_RDATA, MEM_ACK  : memory response (ACK is a one-cycle pulse)
//   STALL               : freeze upstream and hold EX inputs stable
//   MEM_FAULT, MISALIGN : one-cycle error pulses
//   WB_DATA/RD/
//   WRITE_ENABLE        : MEM/WB register outputs
module mem_access_stage
  import rv32_mem_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int TO_CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  EX_FUNC3,
  input  logic        EX_WRITE_ENABLE,
  input  logic        EX_DATA_MEM_SELECT,
  input  logic        EX_MEM_WRITE,
  input  logic        EX_MEM_READ,
  input  logic [31:0] EX_JAL_SELECTED,
  input  logic [31:0] EX_READ_DATA2,
  input  logic [4:0]  EX_RD,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_WSTRB,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        STALL,
  output logic        MEM_FAULT,
  output logic        MISALIGN,
  output logic [31:0] WB_DATA,
  output logic [4:0]  WB_RD,
  output logic        WB_WRITE_ENABLE
);

  localparam logic [TO_CNT_W-1:0] LAST_CNT = TO_CNT_W'(MEM_TIMEOUT - 1);

  state_e              state_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [3:0]          mem_wstrb_q;
  logic                fault_q;
  logic [31:0]         wb_data_q;
  logic [4:0]          wb_rd_q;
  logic                wb_we_q;

  logic        mem_op;
  logic        misaligned;
  logic [1:0]  offset;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;

  assign mem_op = EX_MEM_READ | EX_MEM_WRITE;
  assign offset = EX_JAL_SELECTED[1:0];
  assign cnt_d  = cnt_q + 1'b1;

  load_store_align u_align (
    .func3_i      (EX_FUNC3),
    .offset_i     (offset),
    .store_data_i (EX_READ_DATA2),
    .read_word_i  (MEM_RDATA),
    .wstrb_o      (lane_strb),
    .wdata_o      (lane_wdata),
    .load_data_o  (load_value)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  size_e acc_size;
  logic  misalign_q;

  assign acc_size   = access_size(EX_FUNC3, EX_MEM_WRITE);
  assign misaligned = mem_op &&
                      (((acc_size == SZ_HALF) && offset[0]) ||
                       ((acc_size == SZ_WORD) && (offset != 2'b00)));
  assign MISALIGN   = misalign_q;
`else
  assign misaligned = 1'b0;
  assign MISALIGN   = 1'b0;
`endif

  // STALL is forced low during reset so a reset taken mid-access releases upstream at once.
  always_comb begin
    STALL = 1'b0;
    if (!RST) begin
      if (state_q == WAIT) STALL = !MEM_ACK;
      else                 STALL = mem_op && !misaligned;
    end
  end

  // Handshake FSM and MEM/WB register. A simultaneous read+write is issued as a store.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      fault_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      fault_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      if (state_q == IDLE) begin
        if (mem_op && !misaligned) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= EX_MEM_WRITE;
          mem_addr_q  <= {EX_JAL_SELECTED[31:2], 2'b00};
          mem_wdata_q <= lane_wdata;
          mem_wstrb_q <= lane_strb;
          wb_we_q     <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else if (mem_op) begin
          misalign_q <= 1'b1;
          wb_we_q    <= 1'b0;
          wb_rd_q    <= EX_RD;
        end
`endif
        else begin
          wb_data_q <= EX_JAL_SELECTED;
          wb_rd_q   <= EX_RD;
          wb_we_q   <= EX_WRITE_ENABLE;
        end
      end else begin
        // An ACK on the last allowed wait cycle still completes the access.
        if (MEM_ACK) begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
          wb_rd_q   <= EX_RD;
          if (EX_MEM_WRITE) begin
            wb_we_q <= 1'b0;
          end else begin
            wb_we_q   <= EX_WRITE_ENABLE;
            wb_data_q <= EX_DATA_MEM_SELECT ? load_value : EX_JAL_SELECTED;
          end
        end else if (cnt_q == LAST_CNT) begin
          mem_req_q <= 1'b0;
          fault_q   <= 1'b1;
          wb_we_q   <= 1'b0;
          wb_rd_q   <= EX_RD;
          state_q   <= IDLE;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign MEM_REQ         = mem_req_q;
  assign MEM_WE          = mem_we_q;
  assign MEM_ADDR        = mem_addr_q;
  assign MEM_WDATA       = mem_wdata_q;
  assign MEM_WSTRB       = mem_wstrb_q;
  assign MEM_FAULT       = fault_q;
  assign WB_DATA         = wb_data_q;
  assign WB_RD           = wb_rd_q;
  assign WB_WRITE_ENABLE = wb_we_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; consumes the execute stage's result, store data, rd, func3 and memory/writeback controls.
- Runs a request/acknowledge handshake with the data memory and steers byte/halfword lanes for loads and stores.
- Stalls the pipeline while an access is outstanding and registers the result toward writeback (the MEM/WB register lives here).

Parameters:
- MEM_TIMEOUT, 255, max WAIT cycles without MEM_ACK before the access is abandoned; legal range 1..65535.
- TO_CNT_W, 16, width of the timeout counter.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- EX_FUNC3  in  3  load/store size and sign (RV32 encoding)
- EX_WRITE_ENABLE  in  1  instruction writes rd
- EX_DATA_MEM_SELECT  in  1  1 = writeback takes load data, 0 = takes EX_JAL_SELECTED
- EX_MEM_WRITE  in  1  store
- EX_MEM_READ  in  1  load
- EX_JAL_SELECTED  in  32  ALU result / PC+4; byte address for memory ops
- EX_READ_DATA2  in  32  store data
- EX_RD  in  5  destination register
- MEM_REQ  out  1  request valid to data memory
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  32  word-aligned address {addr[31:2],2'b00}
- MEM_WDATA  out  32  lane-replicated store data
- MEM_WSTRB  out  4  byte enables
- MEM_RDATA  in  32  read word, valid with MEM_ACK
- MEM_ACK  in  1  access complete, single-cycle pulse
- STALL  out  1  freeze upstream stages and hold EX inputs stable
- MEM_FAULT  out  1  one-cycle pulse on timeout
- MISALIGN  out  1  one-cycle pulse on misaligned access (optional feature)
- WB_DATA  out  32  writeback value
- WB_RD  out  5  writeback register
- WB_WRITE_ENABLE  out  1  writeback strobe

Behaviour:
- Reset (async, active-high): state IDLE, timeout counter 0, every output 0. Asserting reset during WAIT drops MEM_REQ immediately; a later MEM_ACK is ignored.
- States: IDLE, WAIT.
- IDLE with no memory op:
  - STALL = 0.
  - Next edge: WB_DATA ← EX_JAL_SELECTED, WB_RD ← EX_RD, WB_WRITE_ENABLE ← EX_WRITE_ENABLE.
  - Latency 1 cycle.
- IDLE with EX_MEM_READ or EX_MEM_WRITE:
  - STALL = 1 (combinational).
  - Next edge: register MEM_ADDR, MEM_WE (= EX_MEM_WRITE), MEM_WDATA, MEM_WSTRB; MEM_REQ ← 1; WB_WRITE_ENABLE ← 0; counter ← 0; go to WAIT.
  - If EX_MEM_READ and EX_MEM_WRITE are both set, the access is a store.
- WAIT:
  - MEM_REQ and all request fields stay stable. STALL = !MEM_ACK (combinational path from MEM_ACK is permitted).
  - On the MEM_ACK edge: MEM_REQ ← 0, go to IDLE, and the instruction retires: WB_RD ← EX_RD.
    - Load: WB_WRITE_ENABLE ← EX_WRITE_ENABLE; WB_DATA ← extracted load data if EX_DATA_MEM_SELECT, else EX_JAL_SELECTED.
    - Store: WB_WRITE_ENABLE ← 0.
  - No ACK: counter increments. When counter = MEM_TIMEOUT−1 and still no ACK: MEM_REQ ← 0, MEM_FAULT pulse, retire with WB_WRITE_ENABLE ← 0, go to IDLE.
- Minimum memory-op latency: 2 cycles (ACK in the first WAIT cycle).
- Store lanes, o = addr[1:0]:
  - SB (000): STRB = 0001<<o, WDATA = {4{data[7:0]}}.
  - SH (001): STRB = 0011<<(2·o[1]), WDATA = {2{data[15:0]}}.
  - SW (010): STRB = 1111.
  - Any other func3 is treated as SW.
- Load extraction:
  - LB/LBU (000/100): byte o, sign/zero extended.
  - LH/LHU (001/101): half o[1], sign/zero extended.
  - LW: whole word.
  - Any other func3 is treated as LW.
- Only one access is outstanding at a time. MEM_ACK seen in IDLE is ignored.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Misalignment is defined as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned access issues no request and STALL stays 0.
  - Next edge: MISALIGN pulses and the instruction retires with WB_WRITE_ENABLE ← 0.
- Undefined: the offending low address bits are ignored (half uses o[1], word uses lane 0) and MISALIGN is tied 0.

Decomposition:
- Package rv32_mem_pkg holds:
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {IDLE, WAIT};
  - the default for MEM_TIMEOUT.
- Sub-module load_store_align: purely combinational; inputs func3, offset, store data, read word; outputs WSTRB, WDATA, extended load value.

Test Plan:
- ALU op, EX_JAL_SELECTED=0x1234, rd=5, WE=1 → next cycle WB_DATA=0x1234, WB_RD=5, WB_WRITE_ENABLE=1; STALL never asserted.
- LB at 0x1003, ACK after 3 WAIT cycles with RDATA=0x80FF_FFFF → STALL high for 4 cycles; MEM_ADDR=0x1000; WB_DATA=0xFFFF_FF80.
- SH at 0x2002, data 0xABCD_BEEF → MEM_WSTRB=1100, MEM_WDATA=0xBEEF_BEEF, MEM_WE=1; WB_WRITE_ENABLE stays 0.
- LHU at 0x3000, RDATA=0x1234_8765, ACK in the first WAIT cycle → WB_DATA=0x0000_8765, total latency 2 cycles.
- MEM_TIMEOUT=4, LW with no ACK → MEM_FAULT pulse after 4 WAIT cycles, MEM_REQ low, WB_WRITE_ENABLE=0, back to IDLE.
- RST asserted mid-WAIT → MEM_REQ/STALL drop immediately; a post-reset ACK is ignored. With MEM_MISALIGN_TRAP_EN, LW at 0x4001 → MISALIGN pulse, no MEM_REQ.
